// File: rtl/rv32i_argmax_pkg.sv
// Shared constants, FSM encoding and FP32 ordering key for the argmax coprocessor.
// Optional build macro: ARGMAX_NAN_SKIP_EN (NaN elements never win the scan).
package rv32i_argmax_pkg;

  localparam logic [6:0] OPCODE_RTYPE = 7'h33;
  localparam logic [6:0] FUNCT7_AM    = 7'h05;

  localparam logic [2:0] F3_XWR   = 3'b000;
  localparam logic [2:0] F3_START = 3'b001;
  localparam logic [2:0] F3_STAT  = 3'b010;
  localparam logic [2:0] F3_RIDX  = 3'b011;
  localparam logic [2:0] F3_RMAX  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Maps an FP32 pattern onto an unsigned key whose order matches numeric order
  // (-0 lands just below +0).
  function automatic logic [31:0] fp32_key(input logic [31:0] v);
    return v[31] ? ~v : (v ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/fp32_ord_gt.sv
// Combinational strict greater-than on two FP32 bit patterns via the ordering key.
module fp32_ord_gt
  import rv32i_argmax_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt
);

  assign gt = fp32_key(a) > fp32_key(b);

endmodule

// File: rtl/rv32i_rtype_argmax.sv
// R-type coprocessor: MxN FP32 logit store with a one-element-per-cycle row argmax scan.
// Optional build macro: ARGMAX_NAN_SKIP_EN (NaN elements are skipped by the scan).
module rv32i_rtype_argmax
  import rv32i_argmax_pkg::*;
#(
  parameter int M      = 8,
  parameter int N      = 8,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_addr,
  output logic        rd_we,
  output logic [4:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        accel_busy,
  output logic        accel_done,
  output logic        accel_C_valid
);

  localparam int ROW_W = (M <= 1) ? 1 : $clog2(M);
  localparam int COL_W = (N <= 1) ? 1 : $clog2(N);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N - 1);

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [DATA_W-1:0]   run_max_q, run_max_d;
  logic [COL_W-1:0]    run_idx_q, run_idx_d;
  logic [DATA_W-1:0]   res_max_q, res_max_d;
  logic [COL_W-1:0]    res_idx_q, res_idx_d;
  logic                done_q, done_d;
  logic                cvalid_q, cvalid_d;
  logic [DATA_W-1:0]   mat_q [M][N];
  logic [DATA_W-1:0]   mat_d [M][N];
`ifdef ARGMAX_NAN_SKIP_EN
  logic                seeded_q, seeded_d;
  logic                elem_nan;
`endif

  logic              accept;
  logic [2:0]        funct3;
  logic [ROW_W-1:0]  wr_row;
  logic [COL_W-1:0]  wr_col;
  logic [DATA_W-1:0] elem;
  logic              elem_gt;
  logic              unused_ok;

  // Handshake: an instruction transfers when instr_valid && instr_ready on a
  // rising edge; instr_ready simply follows rst_n, so there is no back-pressure.
  assign instr_ready = rst_n;
  assign funct3      = instr[14:12];
  assign accept      = instr_valid && instr_ready &&
                       (instr[6:0] == OPCODE_RTYPE) && (instr[31:25] == FUNCT7_AM);
  assign wr_row      = rs1_val[ROW_W+COL_W-1:COL_W];
  assign wr_col      = rs1_val[COL_W-1:0];
  assign elem        = mat_q[row_q][col_q];
  assign unused_ok   = ^{instr[24:15], instr[11:7], rs1_val};

  fp32_ord_gt u_gt (
    .a  (elem),
    .b  (run_max_q),
    .gt (elem_gt)
  );

`ifdef ARGMAX_NAN_SKIP_EN
  assign elem_nan = (elem[30:23] == 8'hFF) && (elem[22:0] != 23'd0);
`endif

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    res_max_d = res_max_q;
    res_idx_d = res_idx_q;
    done_d    = done_q;
    cvalid_d  = cvalid_q;
    mat_d     = mat_q;
`ifdef ARGMAX_NAN_SKIP_EN
    seeded_d  = seeded_q;
`endif

    if (accept && funct3 == F3_XWR && state_q != S_SCAN &&
        32'(wr_row) < M && 32'(wr_col) < N) begin
      mat_d[wr_row][wr_col] = rs2_val;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept && funct3 == F3_START) begin
          row_d    = rs1_val[ROW_W-1:0];
          col_d    = '0;
          done_d   = 1'b0;
          cvalid_d = 1'b0;
          state_d  = S_SCAN;
`ifdef ARGMAX_NAN_SKIP_EN
          seeded_d = 1'b0;
`endif
        end
      end
      S_SCAN: begin
        col_d = col_q + COL_W'(1);
`ifdef ARGMAX_NAN_SKIP_EN
        // The first non-NaN element seeds the running max.
        if (!elem_nan && (!seeded_q || elem_gt)) begin
          run_max_d = elem;
          run_idx_d = col_q;
          seeded_d  = 1'b1;
        end
`else
        if (col_q == '0 || elem_gt) begin
          run_max_d = elem;
          run_idx_d = col_q;
        end
`endif
        if (col_q == LAST_COL) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          cvalid_d  = 1'b1;
          res_max_d = run_max_d;
          res_idx_d = run_idx_d;
`ifdef ARGMAX_NAN_SKIP_EN
          if (!seeded_d) begin
            res_max_d = mat_q[row_q][0];
            res_idx_d = '0;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      res_max_q <= '0;
      res_idx_q <= '0;
      done_q    <= 1'b0;
      cvalid_q  <= 1'b0;
`ifdef ARGMAX_NAN_SKIP_EN
      seeded_q  <= 1'b0;
`endif
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) begin
          mat_q[r][c] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      res_max_q <= res_max_d;
      res_idx_q <= res_idx_d;
      done_q    <= done_d;
      cvalid_q  <= cvalid_d;
`ifdef ARGMAX_NAN_SKIP_EN
      seeded_q  <= seeded_d;
`endif
      mat_q     <= mat_d;
    end
  end

  assign accel_busy    = (state_q == S_SCAN);
  assign accel_done    = done_q;
  assign accel_C_valid = cvalid_q;

  always_comb begin
    rd_we    = 1'b0;
    rd_waddr = 5'd0;
    rd_wdata = 32'd0;
    if (accept && rd_addr != 5'd0 &&
        (funct3 == F3_STAT || funct3 == F3_RIDX || funct3 == F3_RMAX)) begin
      rd_we    = 1'b1;
      rd_waddr = rd_addr;
      case (funct3)
        F3_STAT: rd_wdata = {29'd0, cvalid_q, done_q, accel_busy};
        F3_RIDX: rd_wdata = {{(32-COL_W){1'b0}}, res_idx_q};
        default: rd_wdata = 32'(res_max_q);
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_rtype_argmax.sv
// Directed bench for rv32i_rtype_argmax: row scans, tie/sign ordering, timing, reset and decode filtering.
module tb_rv32i_rtype_argmax;

  localparam int M = 8;
  localparam int N = 8;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        accel_busy;
  logic        accel_done;
  logic        accel_C_valid;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  rv32i_rtype_argmax #(.M(M), .N(N), .DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .rs1_val       (rs1_val),
    .rs2_val       (rs2_val),
    .rd_addr       (rd_addr),
    .rd_we         (rd_we),
    .rd_waddr      (rd_waddr),
    .rd_wdata      (rd_wdata),
    .accel_busy    (accel_busy),
    .accel_done    (accel_done),
    .accel_C_valid (accel_C_valid)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Driver: present one instruction for one cycle, sample writeback mid-cycle.
  task automatic exec(input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [4:0] rd, input logic [6:0] f7,
                      output logic [31:0] wd, output logic we, output logic [4:0] wa);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = {f7, 5'd2, 5'd1, f3, 5'd0, 7'h33};
    rs1_val     = r1;
    rs2_val     = r2;
    rd_addr     = rd;
    #1;
    wd = rd_wdata;
    we = rd_we;
    wa = rd_waddr;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 32'd0;
  endtask

  task automatic read(input logic [2:0] f3, output logic [31:0] wd);
    logic we;
    logic [4:0] wa;
    exec(f3, 32'd0, 32'd0, 5'd7, 7'h05, wd, we, wa);
  endtask

  task automatic write_row(input int row, input logic [31:0] vals [N]);
    logic [31:0] wd;
    logic we;
    logic [4:0] wa;
    for (int c = 0; c < N; c++) begin
      exec(3'b000, 32'((row << 3) | c), vals[c], 5'd0, 7'h05, wd, we, wa);
    end
  endtask

  task automatic start_row(input int row);
    logic [31:0] wd;
    logic we;
    logic [4:0] wa;
    exec(3'b001, 32'(row), 32'd0, 5'd0, 7'h05, wd, we, wa);
  endtask

  // Scoreboard: expected (index, max) pairs are queued before the scan and popped on readback.
  task automatic scan_and_check(input string tag, input int row,
                                input logic [31:0] e_idx, input logic [31:0] e_max);
    logic [31:0] wd;
    logic done_seen;
    exp_q.push_back(e_idx);
    exp_q.push_back(e_max);
    start_row(row);
    done_seen = 1'b0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      read(3'b010, wd);
      done_seen = wd[1];
    end
    check({tag, "_done"}, {31'd0, done_seen}, 32'd1);
    read(3'b011, wd);
    check({tag, "_ridx"}, wd, exp_q.pop_front());
    read(3'b100, wd);
    check({tag, "_rmax"}, wd, exp_q.pop_front());
  endtask

  logic [31:0] row_a [N] = '{32'h3F800000, 32'h40200000, 32'hC0400000, 32'h41100000,
                             32'h40800000, 32'h41000000, 32'h00000000, 32'hBF800000};
  logic [31:0] row_b [N] = '{32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3D800000,
                             32'h00000000, 32'hBF800000, 32'hC0000000, 32'h41200000};
  logic [31:0] row_c [N] = '{32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hBF000000,
                             32'hC0800000, 32'hC1000000, 32'hBE800000, 32'hC1800000};
  logic [31:0] row_t [N] = '{32'h3F800000, 32'h40000000, 32'h40A00000, 32'h40400000,
                             32'h00000000, 32'h40A00000, 32'hBF800000, 32'h40800000};
  logic [31:0] row_z [N] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                             32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000};
  logic [31:0] row_n [N] = '{32'h3F800000, 32'h7FC00000, 32'h40400000, 32'h00000000,
                             32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};

  initial begin
    logic [31:0] wd;
    logic we;
    logic [4:0] wa;

    instr_valid = 1'b0;
    instr       = 32'd0;
    rs1_val     = 32'd0;
    rs2_val     = 32'd0;
    rd_addr     = 5'd0;
    rst_n       = 1'b0;
    #2;
    check("ready_in_reset", {31'd0, instr_ready}, 32'd0);
    check("rdwe_in_reset", {31'd0, rd_we}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("ready_after_reset", {31'd0, instr_ready}, 32'd1);

    read(3'b010, wd);
    check("stat_reset", wd, 32'd0);
    read(3'b011, wd);
    check("ridx_reset", wd, 32'd0);
    read(3'b100, wd);
    check("rmax_reset", wd, 32'd0);

    // Main function over several rows
    write_row(0, row_a);
    scan_and_check("row_a", 0, 32'd3, 32'h41100000);
    write_row(0, row_b);
    scan_and_check("row_b", 0, 32'd7, 32'h41200000);
    write_row(0, row_c);
    scan_and_check("all_neg", 0, 32'd6, 32'hBE800000);
    write_row(0, row_t);
    scan_and_check("tie", 0, 32'd2, 32'h40A00000);
    write_row(5, row_z);
    scan_and_check("negzero_row5", 5, 32'd4, 32'h00000000);
    write_row(6, row_n);
`ifdef ARGMAX_NAN_SKIP_EN
    scan_and_check("nan_row6", 6, 32'd2, 32'h40400000);
`else
    scan_and_check("nan_row6", 6, 32'd1, 32'h7FC00000);
`endif

    // Timing plus XWR-while-busy on row 0 (currently row_a pattern is not loaded; reload it)
    write_row(0, row_a);
    start_row(0);
    read(3'b010, wd);
    check("stat_after_start", wd, 32'd1);
    exec(3'b000, 32'd0, 32'h7F000000, 5'd0, 7'h05, wd, we, wa);
    repeat (N - 1) @(posedge clk);
    read(3'b010, wd);
    check("stat_start_n1", wd, 32'd6);
    scan_and_check("xwr_busy_ignored", 0, 32'd3, 32'h41100000);

    // Writeback to x0 is suppressed
    exec(3'b011, 32'd0, 32'd0, 5'd0, 7'h05, wd, we, wa);
    check("rd0_we", {31'd0, we}, 32'd0);
    check("rd0_wdata", wd, 32'd0);
    exec(3'b100, 32'd0, 32'd0, 5'd9, 7'h05, wd, we, wa);
    check("rd9_we", {31'd0, we}, 32'd1);
    check("rd9_waddr", {27'd0, wa}, 32'd9);

    // Reset during scan
    start_row(0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    read(3'b010, wd);
    check("stat_after_abort", wd, 32'd0);
    read(3'b011, wd);
    check("ridx_after_abort", wd, 32'd0);
    read(3'b100, wd);
    check("rmax_after_abort", wd, 32'd0);

    // Wrong funct7: no writeback, no matrix write, no start
    exec(3'b011, 32'd0, 32'd0, 5'd4, 7'h00, wd, we, wa);
    check("f7_read_we", {31'd0, we}, 32'd0);
    exec(3'b000, 32'd3, 32'h3F800000, 5'd0, 7'h00, wd, we, wa);
    exec(3'b001, 32'd0, 32'd0, 5'd0, 7'h00, wd, we, wa);
    read(3'b010, wd);
    check("f7_no_start", wd, 32'd0);
    scan_and_check("zero_matrix", 0, 32'd0, 32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rv32i_rtype_argmax.md
Name: rv32i_rtype_argmax

Overview:
- Custom RV32I R-type coprocessor that stores an M×N matrix of FP32 logits and computes, per row, the argmax index and the maximum value.
- Sits beside the integer core's execute stage. The core presents a decoded instruction plus register operand values; the block returns a register writeback for read-type ops.
- Used for classifier output selection after the matrix pipeline.

Parameters:
- M, 8, number of rows (logit vectors)
- N, 8, number of columns (classes per row)
- DATA_W, 32, element width (FP32 bit pattern)
- ROW_W (derived), M<=1 ? 1 : clog2(M)
- COL_W (derived), N<=1 ? 1 : clog2(N)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction present this cycle
- instr_ready  out  1  block can accept an instruction
- instr  in  32  raw R-type instruction word
- rs1_val  in  32  rs1 operand value
- rs2_val  in  32  rs2 operand value
- rd_addr  in  5  destination register index
- rd_we  out  1  register writeback strobe
- rd_waddr  out  5  writeback register index
- rd_wdata  out  32  writeback data
- accel_busy  out  1  scan in progress
- accel_done  out  1  last scan finished (sticky)
- accel_C_valid  out  1  result registers hold a valid result

Behaviour:
- Decode: the block accepts an instruction only when instr_valid && instr_ready && opcode==0x33 && funct7==0x05. All other instruction words are ignored and produce no side effects.
- instr_ready is 1 whenever rst_n is high; it is 0 during reset.
- funct3 000 XWR: write X[rs1_val[ROW_W+COL_W-1:COL_W]][rs1_val[COL_W-1:0]] <= rs2_val at the clock edge. XWR is ignored while busy.
- funct3 001 START: latch row = rs1_val[ROW_W-1:0], clear done and C_valid, set busy, and enter SCAN. START is ignored while busy.
- funct3 010 STAT: rd_wdata = {29'b0, C_valid, done, busy}.
- funct3 011 RIDX: rd_wdata = zero-extended result index.
- funct3 100 RMAX: rd_wdata = result max bits.
- Other funct3 values: no side effects, no writeback.
- Writeback timing: for STAT/RIDX/RMAX, rd_wdata, rd_we and rd_waddr (= rd_addr) are combinational in the same cycle instr_valid is high. rd_we is suppressed when rd_addr==0.
- rd_wdata is 0 whenever rd_we is 0.
- Reads are accepted in any state, including during SCAN.
- FSM states:
  - IDLE --START--> SCAN
  - SCAN: compare one element per cycle, col 0..N-1; after N cycles --> DONE
  - DONE: same as IDLE; START re-enters SCAN
- Timing: START is sampled at edge k; busy is 1 from k+1 through k+N; done=1, C_valid=1 and busy=0 from edge k+N+1.
- Comparison: the running max is initialised from column 0. Column j replaces the max only if key(x_j) > key(max), unsigned.
  - key(v) = v[31] ? ~v : v ^ 32'h8000_0000
  - Strict greater-than, so a tie keeps the smallest index.
  - -0 ranks below +0.
  - NaN patterns are ordered by raw key (no special handling) unless the optional feature is enabled.
- Result registers (index, max) update only when a scan completes. They hold their values across XWR.
- Reset values:
  - busy=0, done=0, C_valid=0
  - index=0, max=0
  - state IDLE
  - matrix storage all zero
  - rd_we=0, rd_waddr=0, rd_wdata=0
- Reset asserted mid-scan aborts the scan immediately. All state returns to reset values.

Optional Feature:
- Macro: ARGMAX_NAN_SKIP_EN.
- Defined: any element with exponent==0xFF and mantissa!=0 never replaces the max. If column 0 is NaN, the first non-NaN element seeds the max. If the whole row is NaN, the result is index 0 with max = X[row][0].
- Undefined: NaNs are ordered by raw key as above.

Decomposition:
- Package rv32i_argmax_pkg holds:
  - OPCODE_RTYPE=7'h33, FUNCT7_AM=7'h05
  - F3_XWR, F3_START, F3_STAT, F3_RIDX, F3_RMAX
  - the FSM state enum
  - the fp32_key function
- One natural sub-module: fp32_ord_gt (combinational; strict greater-than on two FP32 bit patterns via key transform).
- Storage, FSM and decode stay in the top module.

Test Plan:
- Row0 = {1.0, 2.5, -3.0, 9.0, 4.0, 8.0, 0.0, -1.0}, START row0, poll STAT until done → RIDX=3, RMAX=0x41100000.
- Row0 = {0.5, 0.25, 0.125, 0.0625, 0, -1, -2, 10.0} → RIDX=7, RMAX=0x41200000.
- All negative, row0 = {-1, -2, -3, -0.5, -4, -8, -0.25, -16} → RIDX=6, RMAX=0xBE800000.
- Tie: 5.0 at columns 2 and 5, others smaller → RIDX=2, RMAX=0x40A00000.
- STAT read the cycle after START → 0x1 (busy only). STAT read at START+N+1 → 0x6. An XWR issued during SCAN leaves the matrix unchanged. A read with rd_addr=0 gives rd_we=0.
- Assert rst_n low during SCAN → busy, done, C_valid, RIDX and RMAX all 0 after release. A non-matching funct7 (0x00) instruction causes no writeback and no state change.
